// File: rtl/latency_arbiter.sv
// rtl/latency_arbiter.sv - round-robin arbiter feeding a fixed-latency shared datapath, with response tag pipeline
// Optional feature: define LATENCY_ARBITER_LOCK_EN to add a per-requester lock input that pins the pointer.
module latency_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 12,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef LATENCY_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  dp_valid,
  output logic [WIDTH-1:0]      dp_din,
  input  logic [WIDTH-1:0]      dp_dout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  issue_q, issue_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [NREQ-1:0]  tag_q [LAT];
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;

  // Circular search starting at ptr_q; the first requesting index wins.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    din_d   = din_q;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        gnt_any = 1'b1;
        din_d   = req_data[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    issue_d = gnt;
    ptr_d   = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`ifdef LATENCY_ARBITER_LOCK_EN
      if (lock[gnt_idx]) ptr_d = gnt_idx;
`endif
    end
  end

  // issue_q sits beside dp_valid; the tag pipeline behind it adds LAT more stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      issue_q <= '0;
      din_q   <= '0;
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      issue_q  <= issue_d;
      din_q    <= din_d;
      tag_q[0] <= issue_q;
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign dp_valid  = |issue_q;
  assign dp_din    = din_q;
  assign rsp_valid = tag_q[LAT-1];
  assign rsp_data  = dp_dout;

endmodule

// File: doc/latency_arbiter.md
LATENCY_ARBITER -- requirements
Module: latency_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 12, bit width of request and response data.
REQ-003 SHALL have parameter LAT, default 2, fixed latency in clocks of the shared datapath (1..16).
REQ-004 SHALL have port clk  input  1  posedge-active clock; the block has one clock.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active high.
REQ-006 SHALL have port req  input  NREQ  per-requester request, held until granted.
REQ-007 SHALL have port req_data  input  NREQ*WIDTH  request operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, combinational from req and the priority pointer.
REQ-009 SHALL have port dp_valid  output  1  registered issue strobe to the shared datapath.
REQ-010 SHALL have port dp_din  output  WIDTH  registered operand to the shared datapath.
REQ-011 SHALL have port dp_dout  input  WIDTH  datapath result, valid LAT clocks after dp_valid.
REQ-012 SHALL have port rsp_valid  output  NREQ  one-hot response strobe identifying the result's owner.
REQ-013 SHALL have port rsp_data  output  WIDTH  result routed back, equal to dp_dout.

Function
REQ-014 SHALL grant at most one requester per cycle using round-robin order, with the search starting at pointer ptr.
REQ-015 SHALL assert gnt[i] only when req[i] is high; gnt SHALL be all-zero when req is all-zero.
REQ-016 SHALL, at a posedge with gnt[i] high, register dp_valid=1 and dp_din=req_data slice i; a requester seeing gnt[i] high SHALL treat the request as accepted at that edge.
REQ-017 SHALL register dp_valid=0 at a posedge with no grant; dp_din SHALL hold its previous value.
REQ-018 SHALL advance ptr to (i+1) mod NREQ after a grant to i; ptr SHALL hold when there is no grant.
REQ-019 SHALL issue back-to-back every clock without bubbles while any req is high, for a throughput of 1 per clock.
REQ-020 SHALL carry the one-hot grant tag through a LAT-stage tag shift register clocked alongside the datapath.
REQ-021 SHALL drive rsp_valid from the tag register's last stage, so that rsp_valid[i] rises exactly LAT clocks after the dp_valid issued for i.
REQ-022 SHALL pass dp_dout to rsp_data combinationally; rsp_data is meaningful only while rsp_valid is non-zero.
REQ-023 SHALL keep in-flight tags independent of new grants, so responses keep their order and ownership while issue continues.
REQ-024 SHALL treat a requester whose req drops before grant as withdrawn; no issue SHALL occur for it.

Reset
REQ-025 SHALL, while rst is high, force ptr=0, dp_valid=0, dp_din=0, every tag stage=0 and rsp_valid=0, independent of clk.
REQ-026 SHALL discard requests in flight when rst asserts mid-operation; no rsp_valid SHALL appear for them after release.
REQ-027 SHALL, at the first posedge after rst release, grant from ptr=0 (lowest index first).

Configuration
REQ-028 SHALL, when macro LATENCY_ARBITER_LOCK_EN is defined, add input lock (width NREQ); a granted requester holding lock[i]=1 SHALL keep ptr at i so that it wins consecutive cycles while req[i] and lock[i] stay high.
REQ-029 SHALL, when LATENCY_ARBITER_LOCK_EN is undefined, omit the lock port and always apply strict rotation as in REQ-018.

Verification (NREQ=4, WIDTH=12, LAT=2)
REQ-030 SHALL cover: after reset, req=4'b0001 with data 0x123 for one cycle -> gnt=0001; dp_valid=1 and dp_din=0x123 next cycle; rsp_valid=0001 two clocks later with rsp_data equal to dp_dout.
REQ-031 SHALL cover: req=4'b1111 held for 8 clocks -> grants in order 0,1,2,3,0,1,2,3, dp_valid high for 8 consecutive clocks, and rsp_valid following the same order delayed by 2.
REQ-032 SHALL cover: req=4'b1010 with ptr=2 -> gnt=1000, then gnt=0010; no grant goes to requesters 0 or 2.
REQ-033 SHALL cover: rst pulsed while 2 results are in flight -> rsp_valid stays 0 through the following 4 clocks and ptr=0 after release.
REQ-034 SHALL cover: with LATENCY_ARBITER_LOCK_EN defined, req=1111 and lock=0100 -> requester 2 is granted on every clock while lock[2] is high; after lock[2] drops, the next grant goes to 3.
REQ-035 SHALL cover: req toggled 1-0-1 on requester 1 with no other requests -> dp_valid pattern 1,0,1 and rsp_valid[1] pattern 1,0,1 delayed by 2.
